// File: rtl/nvme_pkg.sv
// rtl/nvme_pkg.sv - shared NVMe register offsets, bit positions and init FSM states
package nvme_pkg;

  localparam logic [15:0] CAP_LO_OFS = 16'h0000;
  localparam logic [15:0] CAP_HI_OFS = 16'h0004;
  localparam logic [15:0] CC_OFS     = 16'h0014;
  localparam logic [15:0] CSTS_OFS   = 16'h001C;

  localparam int CC_EN_BIT    = 0;
  localparam int CSTS_RDY_BIT = 0;
  localparam int CAP_TO_MSB   = 31;
  localparam int CAP_TO_LSB   = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAP_LO,
    ST_CAP_HI,
    ST_CC_RD,
    ST_CC_WR,
    ST_POLL,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/nvme_tmo_counter.sv
// rtl/nvme_tmo_counter.sv - prescaled CAP.TO-unit timeout counter
module nvme_tmo_counter #(
  parameter int CLKS_PER_UNIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic [7:0] limit,
  output logic       expired
);

  localparam int PW = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_UNIT - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [8:0]    units_q, units_d;
  logic [8:0]    limit_p1;
  logic          reached;

  assign limit_p1 = {1'b0, limit} + 9'd1;
  assign reached  = (units_q >= limit_p1);
  // Also flag the cycle whose edge completes the last unit, so a poll sample on that edge sees it.
  assign expired  = reached || ((units_q == {1'b0, limit}) && (presc_q == PRESC_MAX));

  always_comb begin
    presc_d = presc_q;
    units_d = units_q;
    if (clr) begin
      presc_d = '0;
      units_d = '0;
    end else if (!reached) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        units_d = units_q + 9'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      units_q <= '0;
    end else begin
      presc_q <= presc_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/nvme_ctrl_init.sv
// rtl/nvme_ctrl_init.sv - NVMe controller enable/disable sequencer over the register port
module nvme_ctrl_init
  import nvme_pkg::*;
#(
  parameter int CLKS_PER_UNIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_enable,
  input  logic        start_disable,
  input  logic [31:0] cc_cfg,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] cap_out,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data
);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic        target_q, target_d;
  logic [31:0] cap_lo_q, cap_lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [63:0] cap_q, cap_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        tmo_expired;

  nvme_tmo_counter #(.CLKS_PER_UNIT(CLKS_PER_UNIT)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != ST_POLL),
    .limit   (cap_q[CAP_TO_MSB:CAP_TO_LSB]),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = 1'b0;
    target_d = target_q;
    cap_lo_d = cap_lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    cap_d    = cap_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_enable) begin
          state_d  = ST_CAP_LO;
          addr_d   = CAP_LO_OFS;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          target_d = 1'b1;
        end else if (start_disable) begin
          state_d  = ST_CC_RD;
          addr_d   = CC_OFS;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          target_d = 1'b0;
        end
      end
      // Reads span two cycles: phase 0 waits for the register file, phase 1 samples.
      ST_CAP_LO: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cap_lo_d = reg_rd_data;
          state_d  = ST_CAP_HI;
          addr_d   = CAP_HI_OFS;
        end
      end
      ST_CAP_HI: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cap_d   = {reg_rd_data, cap_lo_q};
          state_d = ST_CC_WR;
          addr_d  = CC_OFS;
          wdata_d = cc_cfg | (32'd1 << CC_EN_BIT);
          wen_d   = 1'b1;
        end
      end
      ST_CC_RD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = ST_CC_WR;
          wdata_d = reg_rd_data & ~(32'd1 << CC_EN_BIT);
          wen_d   = 1'b1;
        end
      end
      ST_CC_WR: begin
        state_d = ST_POLL;
        addr_d  = CSTS_OFS;
      end
      ST_POLL: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (reg_rd_data[CSTS_RDY_BIT] == target_q) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            error_d = 1'b0;
          end else if (tmo_expired) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      target_q <= 1'b0;
      cap_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cap_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      cap_lo_q <= cap_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cap_q    <= cap_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cap_out     = cap_q;
  assign reg_addr    = addr_q;
  assign reg_wr_data = wdata_q;
  assign reg_wr_en   = wen_q;

endmodule

// File: tb/tb_nvme_ctrl_init.sv
// tb/tb_nvme_ctrl_init.sv - self-checking bench for nvme_ctrl_init
module tb_nvme_ctrl_init;

  localparam int CPU = 16;

  logic        clk = 1'b0;
  logic        reset_n, start_enable, start_disable;
  logic [31:0] cc_cfg;
  logic        busy, done, error;
  logic [63:0] cap_out;
  logic [15:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;

  always #5 clk = ~clk;

  nvme_ctrl_init #(.CLKS_PER_UNIT(CPU)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_enable  (start_enable),
    .start_disable (start_disable),
    .cc_cfg        (cc_cfg),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .cap_out       (cap_out),
    .reg_addr      (reg_addr),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_en     (reg_wr_en),
    .reg_rd_data   (reg_rd_data)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Register file responder: cyc equals the number of edges seen so far.
  int          cyc = 0;
  int          rdy_at = 0;
  int          wr_count = 0;
  int          done_count = 0;
  logic        csts_t = 1'b0;
  logic [63:0] cap_val = '0;
  logic [31:0] cc_mem = '0;
  logic [31:0] last_wr_data = '0;
  logic [15:0] last_wr_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_count <= done_count + 1;
    if (reg_wr_en === 1'b1) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= reg_addr;
      last_wr_data <= reg_wr_data;
      if (reg_addr == 16'h0014) cc_mem <= reg_wr_data;
    end
    case (reg_addr)
      16'h0000: reg_rd_data <= cap_val[31:0];
      16'h0004: reg_rd_data <= cap_val[63:32];
      16'h0014: reg_rd_data <= cc_mem;
      16'h001C: reg_rd_data <= {31'd0, (cyc >= rdy_at) ? csts_t : ~csts_t};
      default:  reg_rd_data <= 32'hDEAD_BEEF;
    endcase
  end

  // Reference model state: what the controller's registers should hold.
  logic [31:0] model_cc  = '0;
  logic [63:0] model_cap = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Polls sample every 2 cycles from the first POLL cycle p; the sample at edge t sees
  // CSTS as of edge t-2. Timeout is (to+1)*CPU cycles after p, checked at samples only.
  function automatic void predict(input int s, input bit en, input int ra, input int to,
                                  output int t, output bit err);
    int p;
    bit fin;
    p   = s + (en ? 5 : 3);
    t   = p;
    err = 1'b0;
    fin = 1'b0;
    while (!fin) begin
      t += 2;
      if (t - 2 >= ra) fin = 1'b1;
      else if (t - p >= (to + 1) * CPU) begin
        err = 1'b1;
        fin = 1'b1;
      end
    end
  endfunction

  task automatic run_seq(input string tag, input bit en, input bit dis, input logic [31:0] cfg,
                         input logic [63:0] cap, input int d, input bit extra, output int lat);
    int          s, t_exp, base_wr, base_done;
    bit          err_exp, use_en;
    logic [31:0] wexp;
    logic [63:0] cap_exp;
    use_en = en;
    @(negedge clk);
    s = cyc + 1;
    if (use_en) begin
      cap_val = cap;
      cap_exp = cap;
      wexp    = cfg | 32'h1;
    end else begin
      cap_exp = model_cap;
      wexp    = model_cc & ~32'h1;
    end
    csts_t = use_en;
    rdy_at = s + (use_en ? 4 : 2) + d;
    predict(s, use_en, rdy_at, int'(cap_exp[31:24]), t_exp, err_exp);
    base_wr   = wr_count;
    base_done = done_count;
    cc_cfg        = cfg;
    start_enable  = en;
    start_disable = dis;
    @(negedge clk);
    start_enable  = 1'b0;
    start_disable = 1'b0;
    check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
    check({tag, "_err_clr"}, {63'd0, error}, 64'd0);
    if (extra) begin
      @(negedge clk);
      start_enable  = 1'b1;
      start_disable = 1'b1;
      @(negedge clk);
      start_enable  = 1'b0;
      start_disable = 1'b0;
    end
    for (int k = 0; k < 500 && done !== 1'b1; k++) @(negedge clk);
    check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
    check({tag, "_done_time"}, 64'(cyc), 64'(t_exp));
    lat = cyc + 1 - s;
    check({tag, "_error"}, {63'd0, error}, {63'd0, err_exp});
    check({tag, "_cap"}, cap_out, cap_exp);
    check({tag, "_wr_cnt"}, 64'(wr_count - base_wr), 64'd1);
    check({tag, "_wr_addr"}, {48'd0, last_wr_addr}, 64'h14);
    check({tag, "_wr_data"}, {32'd0, last_wr_data}, {32'd0, wexp});
    @(negedge clk);
    check({tag, "_busy_fall"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_done_cnt"}, 64'(done_count - base_done), 64'd1);
    check({tag, "_err_sticky"}, {63'd0, error}, {63'd0, err_exp});
    model_cc  = wexp;
    model_cap = cap_exp;
  endtask

  initial begin
    int          lat, s;
    bit          en, dis;
    logic [63:0] rcap;
    reset_n       = 1'b0;
    start_enable  = 1'b0;
    start_disable = 1'b0;
    cc_cfg        = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_cap", cap_out, 64'd0);
    check("rst_addr", {48'd0, reg_addr}, 64'd0);
    check("rst_wdata", {32'd0, reg_wr_data}, 64'd0);
    check("rst_wen", {63'd0, reg_wr_en}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_seq("en_tmo", 1'b1, 1'b0, 32'h0046_0000, 64'h1, 1000000, 1'b0, lat);
    check("en_tmo_lat", 64'(lat), 64'd22);
    run_seq("en_rdy5", 1'b1, 1'b0, 32'h0046_0000, 64'h0200_0001, 5, 1'b0, lat);
    check("en_rdy5_lat", {63'd0, (lat >= 12 && lat <= 13)}, 64'd1);
    run_seq("dis_rdy3", 1'b0, 1'b1, 32'hFFFF_FFFF, 64'h0, 3, 1'b0, lat);
    run_seq("en_fast", 1'b1, 1'b0, 32'h0000_0010, 64'h0100_0000, 0, 1'b0, lat);
    check("en_fast_lat", 64'(lat), 64'd8);
    run_seq("dis_fast", 1'b0, 1'b1, 32'h0, 64'h0, 0, 1'b0, lat);
    check("dis_fast_lat", 64'(lat), 64'd6);
    run_seq("both_busy", 1'b1, 1'b1, 32'h1234_0000, 64'h0100_00AA, 2, 1'b1, lat);
    run_seq("tie_ok", 1'b1, 1'b0, 32'h0000_0100, 64'h0, 15, 1'b0, lat);
    run_seq("tie_tmo", 1'b1, 1'b0, 32'h0000_0100, 64'h0, 16, 1'b0, lat);

    // Reset in the middle of POLL abandons the sequence.
    @(negedge clk);
    s       = cyc + 1;
    cap_val = 64'h0000_0007_0000_0003;
    csts_t  = 1'b1;
    rdy_at  = s + 1000000;
    cc_cfg  = 32'h00AB_0000;
    start_enable = 1'b1;
    @(negedge clk);
    start_enable = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_wen", {63'd0, reg_wr_en}, 64'd0);
    check("mid_rst_cap", cap_out, 64'd0);
    check("mid_rst_done_err", {62'd0, done, error}, 64'd0);
    reset_n   = 1'b1;
    model_cc  = 32'h00AB_0001;
    model_cap = '0;
    run_seq("post_rst", 1'b1, 1'b0, 32'h0055_0000, 64'h0100_0002, 1, 1'b0, lat);

    for (int i = 0; i < 8; i++) begin
      en   = 1'($urandom_range(0, 1));
      dis  = en ? 1'($urandom_range(0, 1)) : 1'b1;
      rcap = {$urandom, 8'($urandom_range(0, 3)), 24'($urandom)};
      run_seq($sformatf("rnd%0d", i), en, dis, $urandom, rcap, int'($urandom_range(0, 90)), 1'b0, lat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nvme_ctrl_init.md
# nvme_ctrl_init

Host-side initiator for the NVMe controller register file. It sequences controller enable and disable over the register access port: reads CAP, read-modify-writes CC.EN, and polls CSTS.RDY with a timeout derived from CAP.TO. It sits between host/bring-up control logic and the register file's addr/wr_data/wr_en/rd_data port, and replaces ad-hoc bench sequences with one reusable block.

## Interface
Parameters:
- CLKS_PER_UNIT, 16: clock cycles per CAP.TO unit (500 ms in silicon; small for simulation).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock, synchronous, active-low
- start_enable  in  1  pulse: run enable sequence
- start_disable  in  1  pulse: run disable sequence
- cc_cfg  in  32  CC value written on enable; bit 0 ignored and forced to 1
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end (success or timeout)
- error  out  1  last sequence timed out; sticky until next accepted start
- cap_out  out  64  CAP captured by the last enable sequence
- reg_addr  out  16  register address
- reg_wr_data  out  32  write data
- reg_wr_en  out  1  write strobe, one cycle per write
- reg_rd_data  in  32  read data from register file

## Operation
- Offsets: CAP_LO 0x0000, CAP_HI 0x0004, CC 0x0014, CSTS 0x001C. CC.EN = bit 0, CSTS.RDY = bit 0, CAP.TO = CAP[31:24].
- States: IDLE, CAP_LO, CAP_HI, CC_RD, CC_WR, POLL, FINISH.
- IDLE: start_enable -> CAP_LO; start_disable -> CC_RD. Both asserted together -> enable wins. Starts while busy are ignored. An accepted start clears error.
- Enable path: CAP_LO -> CAP_HI (load cap_out) -> CC_WR (write cc_cfg | 1) -> POLL until RDY=1.
- Disable path: CC_RD (capture CC) -> CC_WR (write captured CC & ~1) -> POLL until RDY=0. cap_out is unchanged.
- POLL: reads CSTS back-to-back and compares RDY with the target value. A match goes to FINISH with error=0.
- Timeout: limit is (TO+1) × CLKS_PER_UNIT cycles, counted from the first POLL cycle. TO is from the current cap_out; on disable it is the last captured value (0 after reset). On expiry go to FINISH with error=1.
- If a RDY match and timeout expiry happen on the same sample, success wins.
- FINISH: done=1 for one cycle, then IDLE.
- Register outputs hold their last value when not in use. reg_wr_en=0 outside CC_WR.

## Timing
- All outputs are registered.
- Reset values: busy 0, done 0, error 0, cap_out 0, reg_addr 0, reg_wr_data 0, reg_wr_en 0, state IDLE.
- Reset mid-sequence forces all reset values at the next edge and abandons the sequence, with no partial write.
- busy rises on the edge that accepts a start. It falls on the edge that ends FINISH, so busy and done overlap for one cycle.
- Read transaction (register file latency is 1 edge):
  - reg_addr is driven at edge E0.
  - The target registers its data at E1.
  - The initiator samples reg_rd_data at E2, and drives the next reg_addr at E2.
  - Each read therefore takes 2 cycles.
- Write transaction: reg_addr=0x14, reg_wr_data and reg_wr_en=1 are valid for exactly one cycle.
- Latency, start to done with immediate RDY:
  - Enable: 2 (CAP_LO) + 2 (CAP_HI) + 1 (CC_WR) + 2 (first poll) + 1 (FINISH) = 8 cycles.
  - Disable: 2 + 1 + 2 + 1 = 6 cycles.
- Timeout counter:
  - Prescaler counts 0..CLKS_PER_UNIT-1.
  - A 9-bit unit counter increments on prescaler wrap.
  - Expiry when the unit counter reaches TO+1 (max 256), so no wrap.
  - The timeout is checked only at poll sample edges, so it can be detected up to 1 cycle late.

## Structure
- Package nvme_pkg holds:
  - register offset localparams;
  - CC_EN_BIT and CSTS_RDY_BIT;
  - CAP_TO_MSB/LSB;
  - the state enum.
  - The register file shares these offsets.
- Sub-module nvme_tmo_counter: prescaler plus unit counter, with inputs clr, limit[7:0] and output expired. Same clk/reset_n.

## Test plan
All scenarios use CLKS_PER_UNIT=16 unless stated.
- Enable against the register-file model (CAP=0x1, CSTS stuck 0), cc_cfg=0x00460000:
  - cap_out = 0x0000_0000_0000_0001;
  - exactly one write of 0x00460001 to 0x0014;
  - timeout after about 16 POLL cycles;
  - done pulse with error=1.
- Bench responder with CAP=0x02000001 (TO=2) that sets RDY 5 cycles after the CC write: done with error=0, total 12–13 cycles, no timeout before 48 POLL cycles.
- Disable with CC=0x00460001 and RDY dropping 3 cycles after the write: write data 0x00460000, done, error=0, cap_out unchanged.
- Simultaneous start_enable and start_disable: the enable path is taken. A start pulse during busy is ignored (one done only). error clears on the next accepted start.
- reset_n low for one cycle mid-POLL: next edge busy=0, reg_wr_en=0, cap_out=0. A following start_enable completes normally.
- Responder raises RDY exactly on the sample where the timeout expires: error=0.
